// File: rtl/decode_pkg.sv
// Shared decode definitions: format one-hot constants, functional-unit IDs,
// field widths and the queued entry layout used by the decode mux and queue.
package decode_pkg;

  localparam int ADDRESS_WIDTH       = 64;
  localparam int INST_COUNTER_WIDTH  = 64;
  localparam int INST_MIN_ID_WIDTH   = 7;
  localparam int OPCODE_SIZE         = 6;
  localparam int FUNC_UNIT_CODE_SIZE = 3;
  localparam int PID_SIZE            = 20;
  localparam int TID_SIZE            = 16;
  localparam int FORMAT_WIDTH        = 23;
  localparam int BODY_WIDTH          = 64;

  // One-hot instruction formats, I at bit 0 through XX3 at bit 22
  localparam logic [FORMAT_WIDTH-1:0] FMT_I   = 23'(1) << 0;
  localparam logic [FORMAT_WIDTH-1:0] FMT_B   = 23'(1) << 1;
  localparam logic [FORMAT_WIDTH-1:0] FMT_SC  = 23'(1) << 2;
  localparam logic [FORMAT_WIDTH-1:0] FMT_D   = 23'(1) << 3;
  localparam logic [FORMAT_WIDTH-1:0] FMT_DS  = 23'(1) << 4;
  localparam logic [FORMAT_WIDTH-1:0] FMT_DQ  = 23'(1) << 5;
  localparam logic [FORMAT_WIDTH-1:0] FMT_DX  = 23'(1) << 6;
  localparam logic [FORMAT_WIDTH-1:0] FMT_X   = 23'(1) << 7;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XL  = 23'(1) << 8;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XFX = 23'(1) << 9;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XFL = 23'(1) << 10;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XS  = 23'(1) << 11;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XO  = 23'(1) << 12;
  localparam logic [FORMAT_WIDTH-1:0] FMT_A   = 23'(1) << 13;
  localparam logic [FORMAT_WIDTH-1:0] FMT_M   = 23'(1) << 14;
  localparam logic [FORMAT_WIDTH-1:0] FMT_MD  = 23'(1) << 15;
  localparam logic [FORMAT_WIDTH-1:0] FMT_MDS = 23'(1) << 16;
  localparam logic [FORMAT_WIDTH-1:0] FMT_VA  = 23'(1) << 17;
  localparam logic [FORMAT_WIDTH-1:0] FMT_VC  = 23'(1) << 18;
  localparam logic [FORMAT_WIDTH-1:0] FMT_VX  = 23'(1) << 19;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XX1 = 23'(1) << 20;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XX2 = 23'(1) << 21;
  localparam logic [FORMAT_WIDTH-1:0] FMT_XX3 = 23'(1) << 22;

  // Functional-unit IDs (5 is unassigned)
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FX     = 3'd0;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FP     = 3'd1;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_VX     = 3'd2;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_CR     = 3'd3;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_LS     = 3'd4;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_BRANCH = 3'd6;

  // One queued decoded instruction; body is left-justified, zero-padded
  typedef struct packed {
    logic [FORMAT_WIDTH-1:0]        format;
    logic [OPCODE_SIZE-1:0]         opcode;
    logic [ADDRESS_WIDTH-1:0]       address;
    logic [FUNC_UNIT_CODE_SIZE-1:0] unitType;
    logic [0:INST_COUNTER_WIDTH]    majId;
    logic [INST_MIN_ID_WIDTH-1:0]   minId;
    logic                           is64Bit;
    logic [PID_SIZE-1:0]            pid;
    logic [TID_SIZE-1:0]            tid;
    logic [BODY_WIDTH-1:0]          body;
  } dq_entry_t;

endpackage

// File: rtl/decode_dispatch_queue_if.sv
// Upstream (decode mux) and downstream (dispatch) channels of the queue.
// slave = queue side, master = producer/consumer side.
interface decode_dispatch_queue_if import decode_pkg::*; #(parameter int DEPTH = 8);
  logic                    enable;
  dq_entry_t               in_entry;
  logic                    stall;
  logic                    overflow;
  logic                    valid;
  logic                    ready;
  dq_entry_t               head;
  logic [$clog2(DEPTH):0]  count;

  modport slave  (input enable, in_entry, ready,
                  output stall, overflow, valid, head, count);
  modport master (output enable, in_entry, ready,
                  input stall, overflow, valid, head, count);
endinterface

// File: rtl/decode_queue_mem.sv
// Simple dual-port entry storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module decode_queue_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/decode_dispatch_queue.sv
// Decode-to-dispatch decoupling FIFO. Upstream has no ready, so stall is
// raised one entry early (count >= depth-1) leaving a single skid slot.
// Optional DECODE_QUEUE_PERF_EN adds stall-cycle and high-water counters.
module decode_dispatch_queue import decode_pkg::*; #(
  parameter int depth = 8
) (
  input  logic                      clock_i,
  input  logic                      resetn_i,
  input  logic                      flush_i,
  decode_dispatch_queue_if.slave    q
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [31:0]               stallCycles_o,
  output logic [$clog2(depth):0]    maxOccupancy_o
`endif
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_valid, w_full, w_deq, w_enq, w_drop, w_stall;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(depth));
  assign w_deq   = w_valid & q.ready;
  // a full queue still accepts when the head leaves in the same cycle
  assign w_enq   = q.enable & (~w_full | w_deq);
  assign w_drop  = q.enable & w_full & ~w_deq;
  assign w_stall = (r_count >= CW'(depth - 1));

  // pointers, occupancy and sticky overflow; flush beats enq/deq
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wp <= r_wp + PW'(1);
      if (w_deq) r_rp <= r_rp + PW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
      else if (w_deq && !w_enq) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  logic [$bits(dq_entry_t)-1:0] w_rdata;

  decode_queue_mem #(.WIDTH($bits(dq_entry_t)), .DEPTH(depth)) u_mem (
    .i_clk   (clock_i),
    .i_we    (w_enq & ~flush_i & resetn_i),
    .i_waddr (r_wp),
    .i_wdata (q.in_entry),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  assign q.head     = dq_entry_t'(w_rdata);
  assign q.valid    = w_valid;
  assign q.stall    = w_stall;
  assign q.overflow = r_overflow;
  assign q.count    = r_count;

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0]   r_stall_cyc;
  logic [CW-1:0] r_max_occ;

  // saturating stall-cycle counter and occupancy high-water mark
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_stall_cyc <= '0;
      r_max_occ   <= '0;
    end else begin
      if (w_stall && r_stall_cyc != '1) r_stall_cyc <= r_stall_cyc + 32'd1;
      if (r_count > r_max_occ) r_max_occ <= r_count;
    end
  end

  assign stallCycles_o  = r_stall_cyc;
  assign maxOccupancy_o = r_max_occ;
`endif
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed bench for decode_dispatch_queue (depth 8).
module tb_decode_dispatch_queue;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic resetn, flush;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decode_dispatch_queue_if #(.DEPTH(8)) dq_if();

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] stall_cyc;
  logic [3:0]  max_occ;
`endif

  decode_dispatch_queue #(.depth(8)) dut (
    .clock_i  (clk),
    .resetn_i (resetn),
    .flush_i  (flush),
    .q        (dq_if.slave)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .stallCycles_o  (stall_cyc),
    .maxOccupancy_o (max_occ)
`endif
  );

  function automatic dq_entry_t mk(input int id);
    dq_entry_t e;
    e.format   = FMT_I << (id % 23);
    e.opcode   = 6'(id);
    e.address  = 64'h1000 + 64'(id) * 64'd4;
    e.unitType = 3'(id % 7);
    e.majId    = 65'(id);
    e.minId    = 7'(id + 3);
    e.is64Bit  = id[0];
    e.pid      = 20'(id * 17);
    e.tid      = 16'(id * 5);
    e.body     = {32'(id), 32'hA5A5_0000};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0;
    dq_if.enable = 1'b1; dq_if.in_entry = mk(99); dq_if.ready = 1'b0;
    tick(); tick();
    checks++; if (dq_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dq_if.valid); end
    checks++; if (dq_if.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dq_if.count); end
    checks++; if (dq_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", dq_if.stall); end
    checks++; if (dq_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", dq_if.overflow); end
    resetn = 1'b1; dq_if.in_entry = mk(5);
    tick();
    dq_if.enable = 1'b0;
    checks++; if (dq_if.valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", dq_if.valid); end
    checks++; if (dq_if.head.majId !== 65'd5) begin errors++; $display("FAIL first_majId: got %0d want 5", dq_if.head.majId); end
    dq_if.ready = 1'b1;
    tick();
    dq_if.ready = 1'b0;
    checks++; if (dq_if.count !== 4'd0) begin errors++; $display("FAIL first_drain_count: got %0d want 0", dq_if.count); end
  endtask

  task automatic test_full_enq_deq();
    dq_if.ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      dq_if.enable = 1'b1; dq_if.in_entry = mk(i);
      tick();
    end
    checks++; if (dq_if.count !== 4'd8) begin errors++; $display("FAIL fed_full_count: got %0d want 8", dq_if.count); end
    dq_if.in_entry = mk(9); dq_if.ready = 1'b1;
    checks++; if (dq_if.head.majId !== 65'd1) begin errors++; $display("FAIL fed_head_before: got %0d want 1", dq_if.head.majId); end
    tick();
    dq_if.enable = 1'b0; dq_if.ready = 1'b0;
    checks++; if (dq_if.count !== 4'd8) begin errors++; $display("FAIL fed_count_after: got %0d want 8", dq_if.count); end
    checks++; if (dq_if.overflow !== 1'b0) begin errors++; $display("FAIL fed_overflow: got %b want 0", dq_if.overflow); end
    dq_if.ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      checks++; if (dq_if.valid !== 1'b1 || dq_if.head !== mk(i)) begin
        errors++; $display("FAIL fed_drain[%0d]: got valid=%b majId=%0d want valid=1 majId=%0d", i, dq_if.valid, dq_if.head.majId, i);
      end
      tick();
    end
    dq_if.ready = 1'b0;
    checks++; if (dq_if.valid !== 1'b0) begin errors++; $display("FAIL fed_empty: got %b want 0", dq_if.valid); end
  endtask

  task automatic test_fill_overflow();
    dq_if.ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      dq_if.enable = 1'b1; dq_if.in_entry = mk(i);
      tick();
      if (i == 6) begin
        checks++; if (dq_if.stall !== 1'b0) begin errors++; $display("FAIL stall_at_6: got %b want 0", dq_if.stall); end
      end
    end
    checks++; if (dq_if.stall !== 1'b1) begin errors++; $display("FAIL stall_at_7: got %b want 1", dq_if.stall); end
    dq_if.in_entry = mk(8);
    tick();
    checks++; if (dq_if.count !== 4'd8) begin errors++; $display("FAIL skid_count: got %0d want 8", dq_if.count); end
    checks++; if (dq_if.overflow !== 1'b0) begin errors++; $display("FAIL skid_overflow: got %b want 0", dq_if.overflow); end
    dq_if.in_entry = mk(77);
    tick();
    dq_if.enable = 1'b0;
    checks++; if (dq_if.count !== 4'd8) begin errors++; $display("FAIL drop_count: got %0d want 8", dq_if.count); end
    checks++; if (dq_if.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b want 1", dq_if.overflow); end
    dq_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (dq_if.valid !== 1'b1 || dq_if.head !== mk(i)) begin
        errors++; $display("FAIL drain[%0d]: got valid=%b head=%h want valid=1 head=%h", i, dq_if.valid, dq_if.head, mk(i));
      end
      tick();
    end
    checks++; if (dq_if.valid !== 1'b0 || dq_if.count !== 4'd0) begin
      errors++; $display("FAIL drain_empty: got valid=%b count=%0d want 0/0", dq_if.valid, dq_if.count);
    end
    // ready with nothing queued must not disturb state
    tick();
    dq_if.ready = 1'b0;
    checks++; if (dq_if.count !== 4'd0 || dq_if.overflow !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got count=%0d ovf=%b want 0/1", dq_if.count, dq_if.overflow);
    end
  endtask

  task automatic test_back_to_back();
    dq_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dq_if.enable = 1'b1; dq_if.in_entry = mk(100 + i);
      tick();
      checks++; if (dq_if.valid !== 1'b1 || dq_if.head !== mk(100 + i)) begin
        errors++; $display("FAIL stream_head[%0d]: got valid=%b majId=%0d want 1/%0d", i, dq_if.valid, dq_if.head.majId, 100 + i);
      end
      checks++; if (dq_if.count !== 4'd1 || dq_if.stall !== 1'b0) begin
        errors++; $display("FAIL stream_occ[%0d]: got count=%0d stall=%b want 1/0", i, dq_if.count, dq_if.stall);
      end
    end
    dq_if.enable = 1'b0;
    tick();
    dq_if.ready = 1'b0;
    checks++; if (dq_if.count !== 4'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", dq_if.count); end
  endtask

  task automatic test_flush();
    dq_if.ready = 1'b0;
    for (int i = 31; i <= 35; i++) begin
      dq_if.enable = 1'b1; dq_if.in_entry = mk(i);
      tick();
    end
    checks++; if (dq_if.count !== 4'd5) begin errors++; $display("FAIL preflush_count: got %0d want 5", dq_if.count); end
    dq_if.in_entry = mk(40); dq_if.ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; dq_if.enable = 1'b0; dq_if.ready = 1'b0;
    checks++; if (dq_if.valid !== 1'b0 || dq_if.count !== 4'd0) begin
      errors++; $display("FAIL flush_state: got valid=%b count=%0d want 0/0", dq_if.valid, dq_if.count);
    end
    checks++; if (dq_if.overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow: got %b want 1", dq_if.overflow); end
    dq_if.enable = 1'b1; dq_if.in_entry = mk(41);
    tick();
    dq_if.enable = 1'b0;
    checks++; if (dq_if.valid !== 1'b1 || dq_if.head !== mk(41) || dq_if.count !== 4'd1) begin
      errors++; $display("FAIL postflush_head: got valid=%b majId=%0d count=%0d want 1/41/1", dq_if.valid, dq_if.head.majId, dq_if.count);
    end
    dq_if.ready = 1'b1;
    tick();
    dq_if.ready = 1'b0;
  endtask

`ifdef DECODE_QUEUE_PERF_EN
  task automatic test_perf();
    resetn = 1'b0; dq_if.enable = 1'b0; dq_if.ready = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      dq_if.enable = 1'b1; dq_if.in_entry = mk(i);
      tick();
    end
    dq_if.enable = 1'b0;
    repeat (9) tick();
    dq_if.ready = 1'b1;
    repeat (7) tick();
    dq_if.ready = 1'b0;
    checks++; if (stall_cyc !== 32'd10) begin errors++; $display("FAIL perf_stall_cycles: got %0d want 10", stall_cyc); end
    checks++; if (max_occ !== 4'd7) begin errors++; $display("FAIL perf_max_occ: got %0d want 7", max_occ); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_enq_deq();
    test_fill_overflow();
    test_back_to_back();
    test_flush();
`ifdef DECODE_QUEUE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
